// File: rtl/md5_farm_pkg.sv
// Shared types, constants and LFSR helper for the md5 farm controller.
package md5_farm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RELEASE,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } state_t;

    // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: the
    // feedback bit is the XOR of bits 0, 2, 3 and 5 and enters at bit 15.
    localparam logic [15:0] LFSR_TAP_MASK     = 16'h002D;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic fb;
        fb = ^(cur & LFSR_TAP_MASK);
        return {fb, cur[15:1]};
    endfunction

endpackage

// File: rtl/md5_farm_controller_rr_arbiter.sv
// Combinational round-robin picker: lowest pending index at or above the
// pointer, wrapping around.
module rr_arbiter
    import md5_farm_pkg::*;
#(
    parameter  int CHANNELS = 8,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic [CHANNELS-1:0] pending,
    input  logic [CH_W-1:0]     ptr,
    output logic [CH_W-1:0]     grant,
    output logic                grant_valid
);

    int unsigned idx;

    // Scan offsets from farthest to nearest so the nearest pending wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int unsigned k = CHANNELS; k > 0; k--) begin
            idx = (int'(ptr) + k - 1) % CHANNELS;
            if (pending[idx]) begin
                grant       = CH_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/md5_farm_controller.sv
// Staggered-release controller for an array of md5 calculator channels,
// collecting each digest once onto a channel-tagged valid/ready stream.
module md5_farm_controller
    import md5_farm_pkg::*;
#(
    parameter  int          CHANNELS       = 8,
    parameter  int          DATA_WIDTH     = 128,
    parameter  int          MAX_DELAY      = 5,
    parameter  int          TIMEOUT_CYCLES = 0,
    parameter  logic [15:0] SEED           = 16'h0001,
    localparam int          CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    output logic [CHANNELS-1:0]            ch_reset,
    input  logic [CHANNELS-1:0]            ch_done,
    input  logic [CHANNELS*DATA_WIDTH-1:0] ch_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CH_W-1:0]                out_channel,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           busy,
    output logic                           all_done,
    output logic                           timeout,
    output logic [31:0]                    cycles
);

    localparam int          DW       = $clog2(MAX_DELAY + 2);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

    state_t                  state_q, state_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic [CH_W-1:0]         load_idx_q, load_idx_d;
    logic [DW-1:0]           rel_cnt_q, rel_cnt_d;
    logic [DW-1:0]           delay_q [CHANNELS];
    logic [DW-1:0]           delay_d [CHANNELS];
    logic [CHANNELS-1:0]     ch_reset_q, ch_reset_d;
    logic [CHANNELS-1:0]     reported_q, reported_d;
    logic [CH_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic                    out_valid_q, out_valid_d;
    logic [CH_W-1:0]         out_channel_q, out_channel_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    busy_q, busy_d;
    logic                    all_done_q, all_done_d;
    logic                    timeout_q, timeout_d;
    logic [31:0]             cycles_q, cycles_d;

    logic [CHANNELS-1:0]     pending;
    logic [CH_W-1:0]         grant_idx;
    logic                    grant_valid;
    logic                    collect;
    logic                    busy_now;

    assign pending = ch_done & ~ch_reset_q & ~reported_q;

    rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
        .pending     (pending),
        .ptr         (rr_ptr_q),
        .grant       (grant_idx),
        .grant_valid (grant_valid)
    );

    // Next-state, stream, release and cycle-counter logic.
    always_comb begin
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        load_idx_d    = load_idx_q;
        rel_cnt_d     = rel_cnt_q;
        delay_d       = delay_q;
        ch_reset_d    = ch_reset_q;
        reported_d    = reported_q;
        rr_ptr_d      = rr_ptr_q;
        out_valid_d   = out_valid_q;
        out_channel_d = out_channel_q;
        out_data_d    = out_data_q;
        cycles_d      = cycles_q;

        collect  = (state_q == ST_RELEASE) || (state_q == ST_RUN);
        busy_now = (state_q == ST_LOAD) || collect;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (collect && (!out_valid_q || out_ready) && grant_valid) begin
            out_valid_d           = 1'b1;
            out_channel_d         = grant_idx;
            out_data_d            = ch_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            reported_d[grant_idx] = 1'b1;
            rr_ptr_d              = (grant_idx == CH_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
        end

        if (busy_now && cycles_q != '1) begin
            cycles_d = cycles_q + 32'd1;
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (start) begin
                    reported_d = '0;
                    cycles_d   = '0;
                    load_idx_d = '0;
                    ch_reset_d = '1;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                delay_d[load_idx_q] = DW'(2 + int'(lfsr_q) % MAX_DELAY);
                lfsr_d              = lfsr_next(lfsr_q);
                if (load_idx_q == CH_W'(CHANNELS - 1)) begin
                    rel_cnt_d = '0;
                    state_d   = ST_RELEASE;
                end else begin
                    load_idx_d = load_idx_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                rel_cnt_d = rel_cnt_q + 1'b1;
                for (int unsigned i = 0; i < CHANNELS; i++) begin
                    if (rel_cnt_q == delay_q[i]) begin
                        ch_reset_d[i] = 1'b0;
                    end
                end
                if (rel_cnt_q == DW'(MAX_DELAY + 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if ((&reported_q) && (!out_valid_q || out_ready)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Completion has priority; the counter holds at the limit so the
        // flag and the count are seen together.
        if (TIMEOUT_CYCLES != 0 && busy_now && cycles_q == 32'(TIMEOUT_CYCLES)
            && state_d != ST_DONE) begin
            state_d  = ST_TIMEOUT;
            cycles_d = cycles_q;
        end

        busy_d     = (state_d == ST_LOAD) || (state_d == ST_RELEASE) || (state_d == ST_RUN);
        all_done_d = (state_d == ST_DONE);
        timeout_d  = (state_d == ST_TIMEOUT);
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            lfsr_q        <= SEED_EFF;
            load_idx_q    <= '0;
            rel_cnt_q     <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                delay_q[i] <= '0;
            end
            ch_reset_q    <= '1;
            reported_q    <= '0;
            rr_ptr_q      <= '0;
            out_valid_q   <= 1'b0;
            out_channel_q <= '0;
            out_data_q    <= '0;
            busy_q        <= 1'b0;
            all_done_q    <= 1'b0;
            timeout_q     <= 1'b0;
            cycles_q      <= '0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            load_idx_q    <= load_idx_d;
            rel_cnt_q     <= rel_cnt_d;
            delay_q       <= delay_d;
            ch_reset_q    <= ch_reset_d;
            reported_q    <= reported_d;
            rr_ptr_q      <= rr_ptr_d;
            out_valid_q   <= out_valid_d;
            out_channel_q <= out_channel_d;
            out_data_q    <= out_data_d;
            busy_q        <= busy_d;
            all_done_q    <= all_done_d;
            timeout_q     <= timeout_d;
            cycles_q      <= cycles_d;
        end
    end

    assign ch_reset    = ch_reset_q;
    assign out_valid   = out_valid_q;
    assign out_channel = out_channel_q;
    assign out_data    = out_data_q;
    assign busy        = busy_q;
    assign all_done    = all_done_q;
    assign timeout     = timeout_q;
    assign cycles      = cycles_q;

endmodule

// File: tb/tb_md5_farm_controller.sv
// Randomised bench for md5_farm_controller against a run-time-based
// behavioural model (phases derived from cycles since start).
module tb_md5_farm_controller;

    localparam int C  = 4;
    localparam int M  = 5;
    localparam int TO = 50;
    localparam int DW = 128;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            ready = 1'b0;
    logic [C-1:0]    done_in = '0;
    logic [C*DW-1:0] ch_data = '0;
    logic [C-1:0]    ch_reset;
    logic            out_valid;
    logic [1:0]      out_channel;
    logic [DW-1:0]   out_data;
    logic            busy, all_done, timeout;
    logic [31:0]     cycles;

    md5_farm_controller #(
        .CHANNELS(C), .DATA_WIDTH(DW), .MAX_DELAY(M),
        .TIMEOUT_CYCLES(TO), .SEED(16'h0001)
    ) dut (
        .clock(clk), .reset(rst), .start(start), .ch_reset(ch_reset),
        .ch_done(done_in), .ch_data(ch_data), .out_valid(out_valid),
        .out_ready(ready), .out_channel(out_channel), .out_data(out_data),
        .busy(busy), .all_done(all_done), .timeout(timeout), .cycles(cycles)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state (values visible after the most recent edge).
    bit            m_act, m_done, m_to, m_val;
    int            m_t;
    bit [31:0]     m_cyc;
    bit [C-1:0]    m_rst_o, m_rep;
    int            m_ptr, m_ch;
    logic [DW-1:0] m_dat;
    int            m_dly [C];
    bit [15:0]     m_lfsr;

    // Stimulus control.
    logic [DW-1:0] dat [C];
    int            done_at [C];
    bit            drop_ok [C];
    int            rdy_mode;
    int            bp_cnt;
    int            beats [$];
    int            obs_fall [C];

    function automatic bit [15:0] lfsr_adv(input bit [15:0] s);
        bit [15:0] b;
        b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'd1;
        return (s >> 1) | (b << 15);
    endfunction

    task automatic model_step();
        bit hs, can_pick, done_c, to_c;
        bit [C-1:0] pend;
        int pick, j;
        if (rst) begin
            m_act = 0; m_done = 0; m_to = 0; m_val = 0; m_t = 0; m_cyc = 0;
            m_rst_o = '1; m_rep = '0; m_ptr = 0; m_ch = 0; m_dat = '0;
            m_lfsr = 16'h0001;
            return;
        end
        hs       = m_val && ready;
        can_pick = m_act && (m_t >= C) && (!m_val || ready);
        pend     = done_in & ~m_rst_o & ~m_rep;
        done_c   = m_act && (m_t >= C + M + 2) && (&m_rep) && (!m_val || ready);
        to_c     = m_act && !done_c && (m_cyc == 32'(TO));
        if (hs) m_val = 0;
        if (can_pick) begin
            pick = -1;
            for (int k = 0; k < C; k++) begin
                j = (m_ptr + k) % C;
                if (pick < 0 && pend[j]) pick = j;
            end
            if (pick >= 0) begin
                m_val = 1; m_ch = pick; m_dat = dat[pick];
                m_rep[pick] = 1'b1;
                m_ptr = (pick + 1) % C;
            end
        end
        if (m_act) begin
            for (int i = 0; i < C; i++) m_rst_o[i] = (m_t + 1 <= C + m_dly[i]);
            if (done_c) begin
                m_act = 0; m_done = 1;
                if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
            end else if (to_c) begin
                m_act = 0; m_to = 1;
            end else begin
                m_cyc++; m_t++;
            end
        end else if (start) begin
            m_act = 1; m_t = 0; m_cyc = 0; m_rep = '0; m_done = 0; m_to = 0;
            m_rst_o = '1;
            for (int i = 0; i < C; i++) begin
                m_dly[i] = 2 + int'(m_lfsr % 16'(M));
                m_lfsr   = lfsr_adv(m_lfsr);
            end
        end
    endtask

    task automatic drive();
        for (int i = 0; i < C; i++) begin
            done_in[i] = m_act && done_at[i] >= 0 && m_t >= done_at[i];
            if (drop_ok[i] && m_rep[i] && $urandom_range(0, 1) == 1) done_in[i] = 1'b0;
            ch_data[i*DW +: DW] = dat[i];
        end
        case (rdy_mode)
            0: ready = 1'b1;
            1: ready = ($urandom_range(0, 9) < 7);
            default: begin
                ready = (bp_cnt >= 10);
                if (&done_in) bp_cnt++;
            end
        endcase
    endtask

    task automatic tick();
        drive();
        if (out_valid && ready) beats.push_back(int'(out_channel));
        model_step();
        @(posedge clk);
        #1;
        chk("ch_reset", ch_reset, m_rst_o);
        chk("out_valid", out_valid, m_val);
        if (m_val) begin
            chk("out_channel", out_channel, m_ch);
            chk("out_data", out_data, m_dat);
        end
        chk("busy", busy, m_act);
        chk("all_done", all_done, m_done);
        chk("timeout", timeout, m_to);
        chk("cycles", cycles, m_cyc);
        for (int i = 0; i < C; i++)
            if (obs_fall[i] < 0 && m_act && !ch_reset[i]) obs_fall[i] = m_t;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic do_start();
        for (int i = 0; i < C; i++) begin done_at[i] = -1; obs_fall[i] = -1; end
        beats.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic set_lat(input int lat);
        for (int i = 0; i < C; i++) done_at[i] = C + m_dly[i] + 1 + lat;
    endtask

    task automatic run_to_end(input int budget);
        int n = 0;
        while (m_act && n < budget) begin tick(); n++; end
        chk("run_terminates", m_act, 0);
    endtask

    task automatic drain(input int n);
        int save = rdy_mode;
        rdy_mode = 0;
        repeat (n) tick();
        rdy_mode = save;
    endtask

    task automatic check_release();
        int off;
        for (int i = 0; i < C; i++) begin
            off = obs_fall[i] - C - 1;
            chk("release_offset_range", (off >= 2 && off <= 6), 1);
            chk("release_offset_lfsr", off, m_dly[i]);
        end
    endtask

    task automatic check_beats(input int exp_n);
        bit [C-1:0] seen = '0;
        int dup = 0;
        foreach (beats[k]) begin
            if (seen[beats[k]]) dup++;
            seen[beats[k]] = 1'b1;
        end
        chk("beat_count", beats.size(), exp_n);
        chk("no_duplicate", dup, 0);
    endtask

    initial begin
        int exp_order [4];
        int n_exp;
        for (int i = 0; i < C; i++) begin
            dat[i] = {32{4'(i)}};
            done_at[i] = -1; drop_ok[i] = 0; obs_fall[i] = -1;
        end
        rdy_mode = 0; bp_cnt = 0;

        // Reset and idle.
        do_reset(3);
        chk("rst_ch_reset", ch_reset, 4'hF);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_channel", out_channel, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_all_done", all_done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cycles", cycles, 0);
        repeat (20) tick();
        chk("idle_ch_reset", ch_reset, 4'hF);
        chk("idle_cycles", cycles, 0);

        // Release and in-order drain.
        do_start();
        set_lat(3);
        run_to_end(80);
        check_release();
        check_beats(4);
        chk("drain_all_done", all_done, 1);
        repeat (5) tick();

        // Restart from DONE with backpressure.
        rdy_mode = 2; bp_cnt = 0;
        do_start();
        chk("restart_ch_reset", ch_reset, 4'hF);
        chk("restart_all_done", all_done, 0);
        chk("restart_cycles", cycles, 0);
        set_lat(3);
        run_to_end(80);
        check_release();
        check_beats(4);
        rdy_mode = 0;

        // Round-robin ordering from a fresh pointer.
        do_reset(2);
        do_start();
        done_at[3] = C + M + 3;
        done_at[0] = C + M + 5;
        done_at[2] = C + M + 5;
        done_at[1] = C + M + 7;
        run_to_end(80);
        exp_order = '{3, 0, 2, 1};
        chk("rr_beat_count", beats.size(), 4);
        for (int k = 0; k < 4 && k < beats.size(); k++)
            chk("rr_order", beats[k], exp_order[k]);

        // Timeout with channel 1 silent.
        do_start();
        set_lat(3);
        done_at[1] = -1;
        run_to_end(80);
        drain(3);
        chk("to_timeout", timeout, 1);
        chk("to_cycles", cycles, TO);
        chk("to_all_done", all_done, 0);
        chk("to_busy", busy, 0);
        check_beats(3);

        // Randomised runs, one aborted by reset.
        rdy_mode = 1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < C; i++) dat[i] = {$urandom, $urandom, $urandom, $urandom};
            do_start();
            n_exp = 0;
            for (int i = 0; i < C; i++) begin
                done_at[i] = C + m_dly[i] + 1 + int'($urandom_range(0, 6)) - 2;
                if ($urandom_range(0, 9) == 0) done_at[i] = -1;
                if (done_at[i] >= 0) n_exp++;
                drop_ok[i] = $urandom_range(0, 1) == 1;
            end
            if (r == 3) begin
                repeat (15) tick();
                do_reset(2);
                chk("abort_ch_reset", ch_reset, 4'hF);
                chk("abort_out_valid", out_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_cycles", cycles, 0);
            end else begin
                run_to_end(80);
                drain(3);
                check_beats(n_exp);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
